// File: rtl/level_pkg.sv
// level_pkg
//   Shared constants and types for the level map: screen geometry, block
//   grid dimensions, the map-store FSM state enum and the cell address
//   helper. Shared with the level generator and the renderer.
package level_pkg;

    localparam int SCREEN_WIDTH  = 800;
    localparam int SCREEN_HEIGHT = 600;
    localparam int BLOCK_SIZE    = 10;
    localparam int MAP_COLS      = SCREEN_WIDTH / BLOCK_SIZE;   // 80
    localparam int MAP_ROWS      = SCREEN_HEIGHT / BLOCK_SIZE;  // 60
    localparam int MAP_CELLS     = MAP_COLS * MAP_ROWS;         // 4800
    localparam int MAP_AW        = 13;

    // Pixel -> block conversion without a divider: x/10 == (x*205)>>11
    // for every x in 0..1023 that matters here (exact below 800/600).
    localparam int DIV10_MUL   = 205;
    localparam int DIV10_SHIFT = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    // row*80 + col as (row<<6) + (row<<4) + col.
    function automatic logic [MAP_AW-1:0] cell_addr(input logic [6:0] row,
                                                    input logic [6:0] col);
        logic [MAP_AW-1:0] w_row;
        logic [MAP_AW-1:0] w_col;
        w_row = {6'b0, row};
        w_col = {6'b0, col};
        return (w_row << 6) + (w_row << 4) + w_col;
    endfunction

endpackage

// File: rtl/level_map_ram.sv
// level_map_ram
//   One-bit-wide simple dual-port map storage, written in a form that
//   infers block RAM: one synchronous write port, one synchronous read
//   port with one cycle of read latency. Contents are never reset.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (sampled every cycle)
//   o_rdata  read data, one cycle after i_raddr
module level_map_ram
    import level_pkg::*;
#(
    parameter int DEPTH = MAP_CELLS,
    parameter int AW    = MAP_AW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    logic r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/level_map_store.sv
// level_map_store
//   Holds the 80x60 safe/unsafe block map for a level. A clear pulse wipes
//   the map one cell per cycle, the generator then writes cells during
//   FILL, and after gen_done the map answers pixel queries in READY.
// Ports:
//   clk, arst_n        clock, synchronous active-low reset
//   i_clear            start (or restart) a map wipe; wins over all else
//   i_wr_en/col/row/safe  generator cell write (accepted only in FILL)
//   i_gen_done         generator finished; FILL -> READY
//   o_rdy              map complete and queryable
//   i_q_vld, i_x, i_y  pixel query
//   o_q_vld, o_is_safe query result, two cycles after i_q_vld
//   o_safe_count       safe cells written since the last wipe
//   o_dbg_state        current FSM state
// Handshake: no backpressure anywhere. A strobe (i_wr_en, i_q_vld,
// i_clear, i_gen_done) is consumed in the cycle it is high; o_q_vld is a
// one-cycle strobe that tracks i_q_vld with fixed two-cycle latency.
module level_map_store
    import level_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_clear,
    input  logic        i_wr_en,
    input  logic [6:0]  i_wr_col,
    input  logic [5:0]  i_wr_row,
    input  logic        i_wr_safe,
    input  logic        i_gen_done,
    output logic        o_rdy,
    input  logic        i_q_vld,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    output logic        o_q_vld,
    output logic        o_is_safe,
    output logic [12:0] o_safe_count,
    output state_t      o_dbg_state
);

    state_t            r_state;
    logic              r_rdy;
    logic [MAP_AW-1:0] r_clr_addr;
    logic [12:0]       r_safe_count;

    logic              r_s1_vld;
    logic              r_s1_ok;
    logic [MAP_AW-1:0] r_s1_addr;
    logic              r_s2_vld;
    logic              r_s2_ok;

    logic              w_wr_in_range;
    logic              w_wr_accept;
    logic              w_clr_we;
    logic              w_ram_we;
    logic [MAP_AW-1:0] w_ram_waddr;
    logic              w_ram_wdata;
    logic              w_ram_rdata;
    logic [6:0]        w_q_col;
    logic [6:0]        w_q_row;
    logic              w_q_in_range;

    // ---------------- write arbitration ----------------
    // Gated by arst_n so a reset cycle never disturbs RAM contents.
    assign w_wr_in_range = (i_wr_col < 7'(MAP_COLS)) && (i_wr_row < 6'(MAP_ROWS));
    assign w_wr_accept   = arst_n && (r_state == ST_FILL) && i_wr_en &&
                           !i_clear && w_wr_in_range;
    assign w_clr_we      = arst_n && (r_state == ST_CLEAR);

    // CLEAR and FILL are exclusive, so the two writers never collide.
    assign w_ram_we    = w_clr_we || w_wr_accept;
    assign w_ram_waddr = w_clr_we ? r_clr_addr : cell_addr({1'b0, i_wr_row}, i_wr_col);
    assign w_ram_wdata = w_clr_we ? 1'b0 : i_wr_safe;

    // ---------------- FSM, clear counter, safe counter ----------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_rdy        <= 1'b0;
            r_clr_addr   <= '0;
            r_safe_count <= '0;
        end else if (i_clear) begin
            r_state      <= ST_CLEAR;
            r_rdy        <= 1'b0;
            r_clr_addr   <= '0;
            r_safe_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rdy <= 1'b0;
                end
                ST_CLEAR: begin
                    r_rdy <= 1'b0;
                    if (r_clr_addr == MAP_AW'(MAP_CELLS - 1)) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_FILL;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_wr_accept && i_wr_safe &&
                        (r_safe_count < 13'(MAP_CELLS))) begin
                        r_safe_count <= r_safe_count + 1'b1;
                    end
                    // A write in the same cycle is still taken above.
                    if (i_gen_done) begin
                        r_state <= ST_READY;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_rdy   <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_rdy <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- query pipeline ----------------
    assign w_q_col      = 7'((18'(i_x) * 18'(DIV10_MUL)) >> DIV10_SHIFT);
    assign w_q_row      = 7'((18'(i_y) * 18'(DIV10_MUL)) >> DIV10_SHIFT);
    assign w_q_in_range = (i_x < 10'(SCREEN_WIDTH)) && (i_y < 10'(SCREEN_HEIGHT));

    // Stage 1: coordinates -> address. Out-of-range pixels read cell 0 so
    // the RAM is never addressed past its end; the result is masked anyway.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_ok   <= 1'b0;
            r_s1_addr <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_ok   <= 1'b0;
        end else begin
            r_s1_vld  <= i_q_vld;
            r_s1_ok   <= i_q_vld && w_q_in_range && (r_state == ST_READY);
            r_s1_addr <= w_q_in_range ? cell_addr(w_q_row, w_q_col) : '0;
            // Stage 2 runs alongside the RAM read.
            r_s2_vld  <= r_s1_vld;
            r_s2_ok   <= r_s1_vld && r_s1_ok;
        end
    end

    level_map_ram #(
        .DEPTH (MAP_CELLS),
        .AW    (MAP_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_s1_addr),
        .o_rdata (w_ram_rdata)
    );

    assign o_rdy        = r_rdy;
    assign o_q_vld      = r_s2_vld;
    assign o_is_safe    = r_s2_ok & w_ram_rdata;
    assign o_safe_count = r_safe_count;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_level_map_store.sv
module tb_level_map_store;
    import level_pkg::*;

    logic        clk;
    logic        arst_n;
    logic        i_clear;
    logic        i_wr_en;
    logic [6:0]  i_wr_col;
    logic [5:0]  i_wr_row;
    logic        i_wr_safe;
    logic        i_gen_done;
    logic        o_rdy;
    logic        i_q_vld;
    logic [9:0]  i_x;
    logic [9:0]  i_y;
    logic        o_q_vld;
    logic        o_is_safe;
    logic [12:0] o_safe_count;
    state_t      o_dbg_state;

    int n_vec;
    int n_err;

    level_map_store dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_clear      (i_clear),
        .i_wr_en      (i_wr_en),
        .i_wr_col     (i_wr_col),
        .i_wr_row     (i_wr_row),
        .i_wr_safe    (i_wr_safe),
        .i_gen_done   (i_gen_done),
        .o_rdy        (o_rdy),
        .i_q_vld      (i_q_vld),
        .i_x          (i_x),
        .i_y          (i_y),
        .o_q_vld      (o_q_vld),
        .o_is_safe    (o_is_safe),
        .o_safe_count (o_safe_count),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic write_cell(input logic [6:0] col, input logic [5:0] row,
                              input logic safe, input logic done);
        i_wr_en    = 1'b1;
        i_wr_col   = col;
        i_wr_row   = row;
        i_wr_safe  = safe;
        i_gen_done = done;
        tick();
        i_wr_en    = 1'b0;
        i_gen_done = 1'b0;
    endtask

    task automatic gen_done();
        i_gen_done = 1'b1;
        tick();
        i_gen_done = 1'b0;
    endtask

    // Single isolated query: returns o_q_vld one cycle in and the result
    // two cycles in.
    task automatic do_query(input logic [9:0] x, input logic [9:0] y,
                            output logic v_mid, output logic v, output logic s);
        i_q_vld = 1'b1;
        i_x     = x;
        i_y     = y;
        tick();
        i_q_vld = 1'b0;
        v_mid   = o_q_vld;
        tick();
        v       = o_q_vld;
        s       = o_is_safe;
    endtask

    // Ticks until FILL is seen; returns the number of ticks (or -1).
    task automatic wait_fill(output int n);
        n = -1;
        for (int k = 1; k <= 6000; k++) begin
            tick();
            if (o_dbg_state == ST_FILL) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (o_dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL reset_state got %0d want %0d", o_dbg_state, ST_IDLE);
        end
        n_vec++;
        if ({o_rdy, o_q_vld, o_is_safe} !== 3'b000) begin
            n_err++; $display("FAIL reset_outs got %b want 000", {o_rdy, o_q_vld, o_is_safe});
        end
        n_vec++;
        if (o_safe_count !== 13'd0) begin
            n_err++; $display("FAIL reset_count got %0d want 0", o_safe_count);
        end
        arst_n = 1'b1;
        // IDLE ignores writes and gen_done.
        write_cell(7'd5, 6'd3, 1'b1, 1'b1);
        n_vec++;
        if (o_dbg_state !== ST_IDLE || o_safe_count !== 13'd0 || o_rdy !== 1'b0) begin
            n_err++; $display("FAIL idle_ignore got st=%0d cnt=%0d rdy=%b want st=0 cnt=0 rdy=0",
                              o_dbg_state, o_safe_count, o_rdy);
        end
    endtask

    task automatic test_clear();
        int n;
        int rdy_seen;
        pulse_clear();
        n_vec++;
        if (o_dbg_state !== ST_CLEAR) begin
            n_err++; $display("FAIL clear_enter got %0d want %0d", o_dbg_state, ST_CLEAR);
        end
        rdy_seen = 0;
        n = -1;
        for (int k = 1; k <= 6000; k++) begin
            tick();
            if (o_rdy === 1'b1) rdy_seen++;
            if (o_dbg_state == ST_FILL) begin
                n = k;
                break;
            end
        end
        n_vec++;
        if (n != 4800) begin
            n_err++; $display("FAIL clear_len got %0d want 4800", n);
        end
        n_vec++;
        if (rdy_seen != 0 || o_rdy !== 1'b0) begin
            n_err++; $display("FAIL clear_rdy got %0d rdy cycles want 0", rdy_seen);
        end
        n_vec++;
        if (o_safe_count !== 13'd0) begin
            n_err++; $display("FAIL clear_count got %0d want 0", o_safe_count);
        end
    endtask

    task automatic test_fill_query();
        logic vm, v, s;
        write_cell(7'd5,  6'd3,  1'b1, 1'b0);
        write_cell(7'd79, 6'd59, 1'b1, 1'b0);
        write_cell(7'd0,  6'd0,  1'b0, 1'b0);
        write_cell(7'd80, 6'd0,  1'b1, 1'b0);  // col out of range
        write_cell(7'd0,  6'd60, 1'b1, 1'b0);  // row out of range
        n_vec++;
        if (o_safe_count !== 13'd2) begin
            n_err++; $display("FAIL fill_count got %0d want 2", o_safe_count);
        end
        gen_done();
        n_vec++;
        if (o_dbg_state !== ST_READY || o_rdy !== 1'b1) begin
            n_err++; $display("FAIL fill_ready got st=%0d rdy=%b want st=3 rdy=1", o_dbg_state, o_rdy);
        end
        // READY ignores writes.
        write_cell(7'd1, 6'd1, 1'b1, 1'b0);
        n_vec++;
        if (o_safe_count !== 13'd2) begin
            n_err++; $display("FAIL ready_wr_count got %0d want 2", o_safe_count);
        end
        do_query(10'd55, 10'd35, vm, v, s);
        n_vec++;
        if (vm !== 1'b0 || v !== 1'b1 || s !== 1'b1) begin
            n_err++; $display("FAIL q_55_35 got mid=%b vld=%b safe=%b want 0 1 1", vm, v, s);
        end
        do_query(10'd45, 10'd35, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b0) begin
            n_err++; $display("FAIL q_45_35 got vld=%b safe=%b want 1 0", v, s);
        end
        do_query(10'd15, 10'd15, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b0) begin
            n_err++; $display("FAIL q_ready_wr got vld=%b safe=%b want 1 0", v, s);
        end
    endtask

    task automatic test_ready_bounds();
        logic vm, v, s;
        do_query(10'd800, 10'd0, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b0) begin
            n_err++; $display("FAIL q_x800 got vld=%b safe=%b want 1 0", v, s);
        end
        do_query(10'd0, 10'd600, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b0) begin
            n_err++; $display("FAIL q_y600 got vld=%b safe=%b want 1 0", v, s);
        end
        do_query(10'd799, 10'd599, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b1) begin
            n_err++; $display("FAIL q_799_599 got vld=%b safe=%b want 1 1", v, s);
        end
        do_query(10'd0, 10'd0, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b0) begin
            n_err++; $display("FAIL q_0_0 got vld=%b safe=%b want 1 0", v, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got_v, got_s;
        i_q_vld = 1'b1; i_x = 10'd55;  i_y = 10'd35;  tick();
        i_x = 10'd45;  i_y = 10'd35;  tick();
        got_v[0] = o_q_vld; got_s[0] = o_is_safe;
        i_x = 10'd799; i_y = 10'd599; tick();
        got_v[1] = o_q_vld; got_s[1] = o_is_safe;
        i_q_vld = 1'b0; tick();
        got_v[2] = o_q_vld; got_s[2] = o_is_safe;
        tick();
        n_vec++;
        if (got_v !== 3'b111 || got_s !== 3'b101) begin
            n_err++; $display("FAIL b2b got vld=%b safe=%b want 111 101", got_v, got_s);
        end
        n_vec++;
        if (o_q_vld !== 1'b0) begin
            n_err++; $display("FAIL b2b_tail got %b want 0", o_q_vld);
        end
    endtask

    task automatic test_clear_collision();
        int n;
        pulse_clear();
        wait_fill(n);
        n_vec++;
        if (n != 4800) begin
            n_err++; $display("FAIL reclear_len got %0d want 4800", n);
        end
        // Clear and a safe write in the same FILL cycle: clear wins.
        i_clear = 1'b1;
        write_cell(7'd7, 6'd7, 1'b1, 1'b0);
        i_clear = 1'b0;
        n_vec++;
        if (o_dbg_state !== ST_CLEAR || o_safe_count !== 13'd0) begin
            n_err++; $display("FAIL coll_clear got st=%0d cnt=%0d want st=1 cnt=0", o_dbg_state, o_safe_count);
        end
        // Restart a wipe in progress: full 4800 cycles again from address 0.
        repeat (100) tick();
        pulse_clear();
        wait_fill(n);
        n_vec++;
        if (n != 4800) begin
            n_err++; $display("FAIL restart_len got %0d want 4800", n);
        end
    endtask

    task automatic test_query_in_fill();
        logic vm, v, s;
        write_cell(7'd6, 6'd4, 1'b1, 1'b0);
        do_query(10'd65, 10'd45, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b0) begin
            n_err++; $display("FAIL q_in_fill got vld=%b safe=%b want 1 0", v, s);
        end
        // Write and gen_done together: write lands, then READY.
        write_cell(7'd8, 6'd8, 1'b1, 1'b1);
        n_vec++;
        if (o_dbg_state !== ST_READY || o_safe_count !== 13'd2) begin
            n_err++; $display("FAIL wr_done got st=%0d cnt=%0d want st=3 cnt=2", o_dbg_state, o_safe_count);
        end
        do_query(10'd65, 10'd45, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b1) begin
            n_err++; $display("FAIL q_after_done got vld=%b safe=%b want 1 1", v, s);
        end
        do_query(10'd85, 10'd85, vm, v, s);
        n_vec++;
        if (v !== 1'b1 || s !== 1'b1) begin
            n_err++; $display("FAIL q_8_8 got vld=%b safe=%b want 1 1", v, s);
        end
        // Cell hit by the dropped write stays clear; old cell (5,3) wiped.
        do_query(10'd75, 10'd75, vm, v, s);
        n_vec++;
        if (s !== 1'b0) begin
            n_err++; $display("FAIL q_dropped got %b want 0", s);
        end
        do_query(10'd55, 10'd35, vm, v, s);
        n_vec++;
        if (s !== 1'b0) begin
            n_err++; $display("FAIL q_wiped got %b want 0", s);
        end
    endtask

    task automatic test_reset_mid_clear();
        pulse_clear();
        repeat (2000) tick();
        n_vec++;
        if (o_dbg_state !== ST_CLEAR) begin
            n_err++; $display("FAIL mid_clear got %0d want %0d", o_dbg_state, ST_CLEAR);
        end
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        n_vec++;
        if (o_dbg_state !== ST_IDLE || o_rdy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got st=%0d rdy=%b want st=0 rdy=0", o_dbg_state, o_rdy);
        end
        write_cell(7'd1, 6'd1, 1'b1, 1'b1);
        n_vec++;
        if (o_dbg_state !== ST_IDLE || o_safe_count !== 13'd0) begin
            n_err++; $display("FAIL post_reset_wr got st=%0d cnt=%0d want st=0 cnt=0", o_dbg_state, o_safe_count);
        end
        pulse_clear();
        n_vec++;
        if (o_dbg_state !== ST_CLEAR) begin
            n_err++; $display("FAIL post_reset_clear got %0d want %0d", o_dbg_state, ST_CLEAR);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_vec      = 0;
        n_err      = 0;
        arst_n     = 1'b0;
        i_clear    = 1'b0;
        i_wr_en    = 1'b0;
        i_wr_col   = '0;
        i_wr_row   = '0;
        i_wr_safe  = 1'b0;
        i_gen_done = 1'b0;
        i_q_vld    = 1'b0;
        i_x        = '0;
        i_y        = '0;

        test_reset();
        test_clear();
        test_fill_query();
        test_ready_bounds();
        test_back_to_back();
        test_clear_collision();
        test_query_in_fill();
        test_reset_mid_clear();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
